sequenciador_sensores: RTL and testbench
========================================

# sequenciador_sensores

Round-robin scheduler that shares one ultrasonic measurement unit among the three level sensors (echo1..3 / trigger1..3) of the tank controller. On a measure request it fires the sensors one at a time, with a guard interval between them to avoid acoustic cross-talk, and collects the three readings. It then reports the median distance, plus a discard flag when the readings disagree. It sits between the control unit (mensurar / fim_medida / descartar_medida) and the shared measurement interface in the datapath.

## Interface
Parameters:
- GUARD_CYCLES, 3_000_000: idle cycles between consecutive sensors (60 ms at 50 MHz).
- TIMEOUT_CYCLES, 1_500_000: maximum wait for a sensor result, in cycles; used only with the timeout feature.
- MAX_SPREAD, 12'd50: largest accepted max−min of the three readings.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; reset is applied while the port is 0.
- mensurar  in  1  start pulse from the control unit; sampled only in IDLE.
- medir  out  1  one-cycle start pulse to the shared measurement unit.
- sel  out  2  selected sensor (0..2); routes trigger/echo muxes in the datapath.
- fim_unidade  in  1  one-cycle pulse from the measurement unit; medida is valid in this cycle.
- medida  in  12  unsigned binary distance from the measurement unit.
- distancia  out  12  registered median of the three readings.
- descartar_medida  out  1  registered; 1 when spread > MAX_SPREAD or any sensor timed out.
- timeout  out  1  registered; 1 if any sensor timed out in the last cycle set.
- fim_medida  out  1  one-cycle pulse; distancia, descartar_medida and timeout are valid in this cycle.
- ocupado  out  1  1 in every state except IDLE.
- db_estado  out  4  state code.
- db_sensor  out  4  {2'b00, sel}.

## Operation
- States and codes:
  - IDLE = 0
  - DISPARA = 1
  - ESPERA = 2
  - GUARDA = 3
  - CALCULA = 4
  - FIM = 5
  - Codes 6–15 are unused and return to IDLE on the next cycle.
- IDLE: on mensurar=1, go to DISPARA with sel=0; the sample registers are not cleared. mensurar is ignored in every other state.
- DISPARA: drive medir=1 for exactly one cycle, clear the wait counter, then go to ESPERA.
- ESPERA: on fim_unidade, store medida into amostra[sel].
  - If sel==2, go to CALCULA.
  - Otherwise clear the guard counter and go to GUARDA.
- GUARDA: count to GUARD_CYCLES−1, then increment sel and go to DISPARA.
- CALCULA: compute min, max and median of the three samples in one cycle.
  - Register distancia = median.
  - Register descartar_medida = (max − min > MAX_SPREAD) | any timeout.
  - Go to FIM.
- FIM: fim_medida=1 for one cycle, then go to IDLE. Result registers hold until the next CALCULA.
- Arithmetic: all comparisons are unsigned 12-bit; max − min cannot underflow. Spread equal to MAX_SPREAD is accepted.
- Duplicate samples are handled normally: for readings (a, a, b) the median is a.
- fim_unidade outside ESPERA is ignored.

## Timing
- Reset values: state=IDLE, sel=0, medir=0, distancia=0, descartar_medida=0, timeout=0, fim_medida=0, ocupado=0, samples=0, all counters=0.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronously). No fim_medida is produced for the aborted request.
- mensurar high at edge k: DISPARA state and medir=1 during cycle k+1.
- fim_unidade for sensor 2 at edge j: CALCULA during cycle j+1; FIM with fim_medida=1 and valid outputs during cycle j+2.
- Between sensors: exactly GUARD_CYCLES cycles in GUARDA, then one DISPARA cycle.
- medir, fim_medida and ocupado are decoded from the registered state. None of them is combinational on inputs.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - In ESPERA, the wait counter runs.
  - On reaching TIMEOUT_CYCLES−1 without fim_unidade, the block stores 12'hFFF as the sample, sets the sticky timeout flag, and proceeds exactly as if fim_unidade had arrived.
  - The flag is cleared on leaving IDLE.
  - If fim_unidade and the timeout coincide, fim_unidade wins.
- SEQ_TIMEOUT_EN undefined: ESPERA waits indefinitely, the timeout port is tied to 0, and no wait counter is synthesized.

## Structure
- Package sensor_seq_pkg holds:
  - the state encodings;
  - NUM_SENSORS = 3;
  - DIST_W = 12;
  - TIMEOUT_SAMPLE = 12'hFFF.
- Sub-module mediana3: combinational; inputs a, b, c; outputs min, max, med, all DIST_W wide.

## Test plan
- Readings 100, 120, 110 → distancia=110, descartar_medida=0, fim_medida one cycle, sel sequence 0,1,2.
- Readings 100, 151, 120 (spread 51 > 50) → distancia=120, descartar_medida=1; readings 100, 150, 120 → descartar_medida=0.
- GUARD_CYCLES=4: measure the gap from fim_unidade to the next medir as 4+1 cycles; mensurar pulsed mid-sequence is ignored.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, sensor 1 silent, other readings 200, 210 → sample 12'hFFF, timeout=1, descartar_medida=1, distancia=210.
- Reset driven 0 during GUARDA of sensor 1 → outputs at reset values immediately. A following mensurar restarts with sel=0.

Source files
------------

// File: rtl/sensor_seq_pkg.sv
// rtl/sensor_seq_pkg.sv - shared types and constants for the sensor sequencer
// State codes, sensor count, distance width and the timeout sample value.
package sensor_seq_pkg;

  localparam int NUM_SENSORS = 3;
  localparam int DIST_W      = 12;
  localparam logic [DIST_W-1:0] TIMEOUT_SAMPLE = 12'hFFF;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DISPARA = 4'd1,
    S_ESPERA  = 4'd2,
    S_GUARDA  = 4'd3,
    S_CALCULA = 4'd4,
    S_FIM     = 4'd5
  } estado_t;

endpackage

// File: rtl/mediana3.sv
// rtl/mediana3.sv - combinational min/max/median of three unsigned readings
module mediana3
  import sensor_seq_pkg::*;
(
  input  logic [DIST_W-1:0] a,
  input  logic [DIST_W-1:0] b,
  input  logic [DIST_W-1:0] c,
  output logic [DIST_W-1:0] min,
  output logic [DIST_W-1:0] max,
  output logic [DIST_W-1:0] med
);

  logic [DIST_W-1:0] lo_ab;
  logic [DIST_W-1:0] hi_ab;

  assign lo_ab = (a < b) ? a : b;
  assign hi_ab = (a < b) ? b : a;

  assign min = (c < lo_ab) ? c : lo_ab;
  assign max = (c > hi_ab) ? c : hi_ab;
  // Median is c clamped into [lo_ab, hi_ab]; duplicates fall out naturally.
  assign med = (c < lo_ab) ? lo_ab : ((c > hi_ab) ? hi_ab : c);

endmodule

// File: rtl/sequenciador_sensores.sv
// rtl/sequenciador_sensores.sv - round-robin scheduler for three ultrasonic sensors (optional SEQ_TIMEOUT_EN)
// Fires sensors 0..2 with a guard gap, then reports the median and a discard flag.
module sequenciador_sensores
  import sensor_seq_pkg::*;
#(
  parameter int unsigned       GUARD_CYCLES   = 3_000_000,
  parameter int unsigned       TIMEOUT_CYCLES = 1_500_000,
  parameter logic [DIST_W-1:0] MAX_SPREAD     = 12'd50
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mensurar,
  output logic              medir,
  output logic [1:0]        sel,
  input  logic              fim_unidade,
  input  logic [DIST_W-1:0] medida,
  output logic [DIST_W-1:0] distancia,
  output logic              descartar_medida,
  output logic              timeout,
  output logic              fim_medida,
  output logic              ocupado,
  output logic [3:0]        db_estado,
  output logic [3:0]        db_sensor
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);

  estado_t           state;
  logic [GW-1:0]     guard_cnt;
  logic [DIST_W-1:0] amostra [0:NUM_SENSORS-1];
  logic [DIST_W-1:0] s_min, s_max, s_med;
  logic              sample_done;
  logic [DIST_W-1:0] sample_val;
  logic              timeout_flag;

  mediana3 u_mediana3 (
    .a   (amostra[0]),
    .b   (amostra[1]),
    .c   (amostra[2]),
    .min (s_min),
    .max (s_max),
    .med (s_med)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;
  logic          timeout_q;

  assign wait_expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  // A real result arriving on the expiry cycle takes priority over the filler.
  assign sample_done  = fim_unidade | wait_expired;
  assign sample_val   = fim_unidade ? medida : TIMEOUT_SAMPLE;
  assign timeout      = timeout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      if (state == S_DISPARA) wait_cnt <= '0;
      else if (state == S_ESPERA) wait_cnt <= wait_cnt + 1'b1;
      if (state == S_IDLE && mensurar) timeout_flag <= 1'b0;
      else if (state == S_ESPERA && wait_expired && !fim_unidade) timeout_flag <= 1'b1;
      if (state == S_CALCULA) timeout_q <= timeout_flag;
    end
  end
`else
  assign sample_done  = fim_unidade;
  assign sample_val   = medida;
  assign timeout_flag = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      sel              <= 2'd0;
      guard_cnt        <= '0;
      amostra          <= '{default: '0};
      distancia        <= '0;
      descartar_medida <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mensurar) begin
            state <= S_DISPARA;
            sel   <= 2'd0;
          end
        end
        S_DISPARA: state <= S_ESPERA;
        S_ESPERA: begin
          if (sample_done) begin
            amostra[sel] <= sample_val;
            if (sel == 2'(NUM_SENSORS - 1)) begin
              state <= S_CALCULA;
            end else begin
              guard_cnt <= '0;
              state     <= S_GUARDA;
            end
          end
        end
        S_GUARDA: begin
          if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
            sel   <= sel + 2'd1;
            state <= S_DISPARA;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        S_CALCULA: begin
          distancia        <= s_med;
          descartar_medida <= ((s_max - s_min) > MAX_SPREAD) | timeout_flag;
          state            <= S_FIM;
        end
        S_FIM:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign medir      = (state == S_DISPARA);
  assign fim_medida = (state == S_FIM);
  assign ocupado    = (state != S_IDLE);
  assign db_estado  = state;
  assign db_sensor  = {2'b00, sel};

endmodule

// File: tb/tb_sequenciador_sensores.sv
// tb/tb_sequenciador_sensores.sv - directed self-checking bench for sequenciador_sensores
module tb_sequenciador_sensores;
  import sensor_seq_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              mensurar = 1'b0;
  logic              medir;
  logic [1:0]        sel;
  logic              fim_unidade = 1'b0;
  logic [DIST_W-1:0] medida = '0;
  logic [DIST_W-1:0] distancia;
  logic              descartar_medida;
  logic              timeout;
  logic              fim_medida;
  logic              ocupado;
  logic [3:0]        db_estado;
  logic [3:0]        db_sensor;

  int n_cmp = 0;
  int n_err = 0;

  int          lat      [3];
  logic [1:0]  sel_seen [3];
  logic        medir_seen [3];
  logic [3:0]  calc_state;
  logic        fim_seen, fim_after, ocup_after, desc_seen, to_seen;
  logic [11:0] dist_seen;

  sequenciador_sensores #(
    .GUARD_CYCLES   (4),
    .TIMEOUT_CYCLES (8),
    .MAX_SPREAD     (12'd50)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mensurar         (mensurar),
    .medir            (medir),
    .sel              (sel),
    .fim_unidade      (fim_unidade),
    .medida           (medida),
    .distancia        (distancia),
    .descartar_medida (descartar_medida),
    .timeout          (timeout),
    .fim_medida       (fim_medida),
    .ocupado          (ocupado),
    .db_estado        (db_estado),
    .db_sensor        (db_sensor)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one full request; silent1 leaves sensor 1 unanswered, poke injects stray inputs during GUARDA.
  task automatic do_sequence(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                             input bit silent1, input bit poke);
    logic [11:0] v [3];
    int n;
    v[0] = a; v[1] = b; v[2] = c;
    @(posedge clock); #1 mensurar = 1'b1;
    @(posedge clock); #1 mensurar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (medir !== 1'b1 && n < 100) begin
        if (poke && i > 0 && n == 1) begin
          mensurar = 1'b1; fim_unidade = 1'b1; medida = 12'd4000;
        end
        @(posedge clock); #1;
        mensurar = 1'b0; fim_unidade = 1'b0;
        n++;
      end
      lat[i] = n; sel_seen[i] = sel; medir_seen[i] = medir;
      @(posedge clock); #1;
      if (!(i == 1 && silent1)) begin
        fim_unidade = 1'b1; medida = v[i];
        @(posedge clock); #1;
        fim_unidade = 1'b0; medida = 12'd0;
      end
    end
    calc_state = db_estado;
    @(posedge clock); #1;
    fim_seen = fim_medida; dist_seen = distancia; desc_seen = descartar_medida; to_seen = timeout;
    @(posedge clock); #1;
    fim_after = fim_medida; ocup_after = ocupado;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;
    n_cmp++; if (medir !== 1'b0) begin n_err++; $display("FAIL reset_medir: got %0b want 0", medir); end
    n_cmp++; if (fim_medida !== 1'b0) begin n_err++; $display("FAIL reset_fim: got %0b want 0", fim_medida); end
    n_cmp++; if (ocupado !== 1'b0) begin n_err++; $display("FAIL reset_ocupado: got %0b want 0", ocupado); end
    n_cmp++; if (distancia !== 12'd0) begin n_err++; $display("FAIL reset_dist: got %0d want 0", distancia); end
    n_cmp++; if (descartar_medida !== 1'b0) begin n_err++; $display("FAIL reset_desc: got %0b want 0", descartar_medida); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
    n_cmp++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
    n_cmp++; if (db_sensor !== 4'd0) begin n_err++; $display("FAIL reset_sensor: got %0d want 0", db_sensor); end
    reset = 1'b1;
  endtask

  task automatic test_median;
    do_sequence(12'd100, 12'd120, 12'd110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (sel_seen[i] !== 2'(i) || medir_seen[i] !== 1'b1) begin
        n_err++; $display("FAIL median_sel%0d: got sel=%0d medir=%0b want sel=%0d medir=1", i, sel_seen[i], medir_seen[i], i);
      end
    end
    n_cmp++; if (lat[0] !== 0) begin n_err++; $display("FAIL median_first_medir: got %0d cycles want 0", lat[0]); end
    n_cmp++; if (calc_state !== 4'd4) begin n_err++; $display("FAIL median_calcula: got state %0d want 4", calc_state); end
    n_cmp++; if (fim_seen !== 1'b1) begin n_err++; $display("FAIL median_fim: got %0b want 1", fim_seen); end
    n_cmp++; if (fim_after !== 1'b0 || ocup_after !== 1'b0) begin
      n_err++; $display("FAIL median_fim_one_cycle: got fim=%0b ocupado=%0b want 0 0", fim_after, ocup_after);
    end
    n_cmp++; if (dist_seen !== 12'd110) begin n_err++; $display("FAIL median_dist: got %0d want 110", dist_seen); end
    n_cmp++; if (desc_seen !== 1'b0) begin n_err++; $display("FAIL median_desc: got %0b want 0", desc_seen); end
    n_cmp++; if (to_seen !== 1'b0) begin n_err++; $display("FAIL median_timeout: got %0b want 0", to_seen); end
  endtask

  task automatic test_spread;
    do_sequence(12'd100, 12'd151, 12'd120, 1'b0, 1'b0);
    n_cmp++; if (dist_seen !== 12'd120) begin n_err++; $display("FAIL spread51_dist: got %0d want 120", dist_seen); end
    n_cmp++; if (desc_seen !== 1'b1) begin n_err++; $display("FAIL spread51_desc: got %0b want 1", desc_seen); end
    do_sequence(12'd100, 12'd150, 12'd120, 1'b0, 1'b0);
    n_cmp++; if (dist_seen !== 12'd120) begin n_err++; $display("FAIL spread50_dist: got %0d want 120", dist_seen); end
    n_cmp++; if (desc_seen !== 1'b0) begin n_err++; $display("FAIL spread50_desc: got %0b want 0", desc_seen); end
  endtask

  task automatic test_duplicates;
    do_sequence(12'd300, 12'd300, 12'd50, 1'b0, 1'b0);
    n_cmp++; if (dist_seen !== 12'd300) begin n_err++; $display("FAIL dup_high_dist: got %0d want 300", dist_seen); end
    n_cmp++; if (desc_seen !== 1'b1) begin n_err++; $display("FAIL dup_high_desc: got %0b want 1", desc_seen); end
    do_sequence(12'd9, 12'd7, 12'd9, 1'b0, 1'b0);
    n_cmp++; if (dist_seen !== 12'd9) begin n_err++; $display("FAIL dup_low_dist: got %0d want 9", dist_seen); end
    do_sequence(12'd4095, 12'd0, 12'd2000, 1'b0, 1'b0);
    n_cmp++; if (dist_seen !== 12'd2000 || desc_seen !== 1'b1) begin
      n_err++; $display("FAIL extreme: got dist=%0d desc=%0b want 2000 1", dist_seen, desc_seen);
    end
  endtask

  task automatic test_guard_and_stray;
    do_sequence(12'd500, 12'd520, 12'd510, 1'b0, 1'b1);
    n_cmp++; if (lat[1] !== 4) begin n_err++; $display("FAIL guard_gap1: got %0d want 4 (gap %0d want 5)", lat[1], lat[1] + 1); end
    n_cmp++; if (lat[2] !== 4) begin n_err++; $display("FAIL guard_gap2: got %0d want 4 (gap %0d want 5)", lat[2], lat[2] + 1); end
    n_cmp++; if (sel_seen[1] !== 2'd1 || sel_seen[2] !== 2'd2) begin
      n_err++; $display("FAIL stray_sel: got %0d,%0d want 1,2", sel_seen[1], sel_seen[2]);
    end
    n_cmp++; if (dist_seen !== 12'd510 || desc_seen !== 1'b0) begin
      n_err++; $display("FAIL stray_result: got dist=%0d desc=%0b want 510 0", dist_seen, desc_seen);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(posedge clock); #1 mensurar = 1'b1;
    @(posedge clock); #1 mensurar = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (medir !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
      @(posedge clock); #1 fim_unidade = 1'b1; medida = 12'd700;
      @(posedge clock); #1 fim_unidade = 1'b0;
    end
    @(posedge clock); #1;
    n_cmp++; if (db_estado !== 4'd3 || db_sensor !== 4'd1) begin
      n_err++; $display("FAIL mid_pre_reset: got estado=%0d sensor=%0d want 3 1", db_estado, db_sensor);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (db_estado !== 4'd0 || ocupado !== 1'b0 || db_sensor !== 4'd0) begin
      n_err++; $display("FAIL mid_async_state: got estado=%0d ocupado=%0b sensor=%0d want 0 0 0", db_estado, ocupado, db_sensor);
    end
    n_cmp++; if (distancia !== 12'd0 || descartar_medida !== 1'b0 || fim_medida !== 1'b0 || medir !== 1'b0) begin
      n_err++; $display("FAIL mid_async_outputs: got dist=%0d desc=%0b fim=%0b medir=%0b want 0 0 0 0",
                        distancia, descartar_medida, fim_medida, medir);
    end
    @(posedge clock); #1 reset = 1'b1;
    do_sequence(12'd10, 12'd30, 12'd20, 1'b0, 1'b0);
    n_cmp++; if (sel_seen[0] !== 2'd0 || lat[0] !== 0) begin
      n_err++; $display("FAIL mid_restart_sel: got sel=%0d lat=%0d want 0 0", sel_seen[0], lat[0]);
    end
    n_cmp++; if (dist_seen !== 12'd20) begin n_err++; $display("FAIL mid_restart_dist: got %0d want 20", dist_seen); end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout;
    do_sequence(12'd200, 12'd0, 12'd210, 1'b1, 1'b0);
    n_cmp++; if (dist_seen !== 12'd210) begin n_err++; $display("FAIL timeout_dist: got %0d want 210", dist_seen); end
    n_cmp++; if (to_seen !== 1'b1 || desc_seen !== 1'b1) begin
      n_err++; $display("FAIL timeout_flags: got to=%0b desc=%0b want 1 1", to_seen, desc_seen);
    end
    do_sequence(12'd200, 12'd205, 12'd210, 1'b0, 1'b0);
    n_cmp++; if (to_seen !== 1'b0 || desc_seen !== 1'b0 || dist_seen !== 12'd205) begin
      n_err++; $display("FAIL timeout_cleared: got to=%0b desc=%0b dist=%0d want 0 0 205", to_seen, desc_seen, dist_seen);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_median;
    test_spread;
    test_duplicates;
    test_guard_and_stray;
    test_reset_mid;
`ifdef SEQ_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
